// File: rtl/exhaustive_sweep_capture.sv
// Exhaustive input sweep generator with response capture.
// Drives every pattern 0..2^N_IN-1 to a DUT and holds each for HOLD cycles.
// It then samples the response and streams {pattern, response} over valid/ready.
// A rotate-xor signature is folded over all responses.
module exhaustive_sweep_capture #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned HOLD  = 1,
  parameter int unsigned SIG_W = 16
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [N_IN-1:0]       N,
  input  logic [N_OUT-1:0]      dut_out,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [N_IN+N_OUT-1:0] rec_data,
  output logic                  busy,
  output logic                  done,
  output logic [SIG_W-1:0]      signature,
  output logic [N_IN:0]         rec_count
);

  localparam int unsigned RecW = N_IN + N_OUT;
  localparam int unsigned CntW = N_IN + 1;
  localparam logic [7:0] HoldLast = 8'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StApply, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   n_q, n_d;
  logic [7:0]        hold_q, hold_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RecW-1:0]   rec_data_q, rec_data_d;
  logic              rec_valid_q, rec_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hold_done;
  logic              xfer;
  logic              n_last;
  logic [SIG_W-1:0]  sig_rot;

  assign hold_done = (hold_q == HoldLast);
  assign xfer      = rec_valid_q & rec_ready;
  assign n_last    = &n_q;
  assign sig_rot   = (sig_q << 1) | (sig_q >> (SIG_W - 1));

  // State register.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats a same-edge transfer or capture.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && !abort) state_d = StApply;
      StApply: begin
        if (abort)          state_d = StIdle;
        else if (hold_done) state_d = StEmit;
      end
      StEmit: begin
        if (abort)     state_d = StIdle;
        else if (xfer) state_d = n_last ? StDone : StApply;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status flags decoded from the next state so they can be registered.
  always_comb begin
    busy_d      = (state_d == StApply) || (state_d == StEmit);
    rec_valid_d = (state_d == StEmit);
    done_d      = (state_d == StDone);
  end

  // Datapath next-state: pattern, hold counter, capture, signature, count.
  always_comb begin
    n_d        = n_q;
    hold_d     = hold_q;
    sig_d      = sig_q;
    cnt_d      = cnt_q;
    rec_data_d = rec_data_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          n_d    = '0;
          hold_d = '0;
          sig_d  = '0;
          cnt_d  = '0;
        end
      end
      StApply: begin
        if (!abort) begin
          hold_d = hold_q + 8'd1;
          if (hold_done) begin
            rec_data_d = {n_q, dut_out};
            sig_d      = sig_rot ^ SIG_W'(dut_out);
          end
        end
      end
      StEmit: begin
        if (!abort && xfer) begin
          cnt_d = cnt_q + CntW'(1);
          // Pattern never wraps past all ones.
          if (!n_last) begin
            n_d    = n_q + N_IN'(1);
            hold_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      n_q         <= '0;
      hold_q      <= '0;
      sig_q       <= '0;
      cnt_q       <= '0;
      rec_data_q  <= '0;
      rec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      n_q         <= n_d;
      hold_q      <= hold_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
      rec_data_q  <= rec_data_d;
      rec_valid_q <= rec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign N         = n_q;
  assign rec_valid = rec_valid_q;
  assign rec_data  = rec_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;
  assign rec_count = cnt_q;

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// Bench for exhaustive_sweep_capture: HOLD=1 instance with a parity DUT,
// plus a HOLD=3 instance driving a two-stage registered parity DUT.
module tb_exhaustive_sweep_capture;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  logic        reset;
  logic        start, abort, rec_ready;
  logic [3:0]  n;
  logic        dut_out;
  logic        rec_valid, busy, done;
  logic [4:0]  rec_data;
  logic [15:0] signature;
  logic [4:0]  rec_count;

  logic        start3, abort3, rec_ready3;
  logic [3:0]  n3;
  logic        dut_out3;
  logic        rec_valid3, busy3, done3;
  logic [4:0]  rec_data3;
  logic [15:0] signature3;
  logic [4:0]  rec_count3;
  logic        p1_q, p2_q;

  logic [4:0]  exp_q[$];
  logic [4:0]  exp3_q[$];

  assign dut_out = ^n;

  always @(posedge CK or negedge reset) begin
    if (!reset) begin
      p1_q <= 1'b0;
      p2_q <= 1'b0;
    end else begin
      p1_q <= ^n3;
      p2_q <= p1_q;
    end
  end
  assign dut_out3 = p2_q;

  exhaustive_sweep_capture #(.N_IN(4), .N_OUT(1), .HOLD(1), .SIG_W(16)) u_dut1 (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .N(n), .dut_out(dut_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data), .busy(busy),
    .done(done), .signature(signature), .rec_count(rec_count)
  );

  exhaustive_sweep_capture #(.N_IN(4), .N_OUT(1), .HOLD(3), .SIG_W(16)) u_dut3 (
    .CK(CK), .reset(reset), .start(start3), .abort(abort3), .N(n3), .dut_out(dut_out3),
    .rec_valid(rec_valid3), .rec_ready(rec_ready3), .rec_data(rec_data3), .busy(busy3),
    .done(done3), .signature(signature3), .rec_count(rec_count3)
  );

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic push_all(input bit which3);
    logic [3:0] pv;
    for (int p = 0; p < 16; p++) begin
      pv = p[3:0];
      if (which3) exp3_q.push_back({pv, ^pv});
      else        exp_q.push_back({pv, ^pv});
    end
  endtask

  // Runs one sweep on the HOLD=1 instance. Negative pattern args disable that feature.
  // done_cyc: edges after the start edge where done was seen; -1 timeout, -2 aborted.
  task automatic run_sweep(input int stall_pat, input int stall_len, input int abort_pat,
                           input int stray_pat, output int done_cyc, output int xfers);
    int          stalled;
    bit          stray_done, stray_chk;
    logic [3:0]  sv_n;
    logic [4:0]  sv_cnt, sv_data, exp;
    logic [15:0] sv_sig;
    logic [3:0]  sp;
    stalled = 0; stray_done = 0; stray_chk = 0; xfers = 0; done_cyc = -1;
    exp_q.delete();
    push_all(1'b0);
    rec_ready = 1'b1; abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, n, signature, rec_count} !== {1'b1, 4'd0, 16'd0, 5'd0})
      $display("FAIL start_state: got busy=%b N=%h sig=%h cnt=%0d, want 1 0 0000 0",
               busy, n, signature, rec_count);
    if ({busy, n, signature, rec_count} !== {1'b1, 4'd0, 16'd0, 5'd0}) errors++;
    for (int k = 0; k < 400; k++) begin
      if (stray_chk) begin
        checks++;
        stray_chk = 0;
        if ({n, rec_count, signature, rec_data} !== {sv_n, sv_cnt, sv_sig, sv_data}) begin
          errors++;
          $display("FAIL stray_start: got N=%h cnt=%0d sig=%h data=%h, want %h %0d %h %h",
                   n, rec_count, signature, rec_data, sv_n, sv_cnt, sv_sig, sv_data);
        end
      end
      if (done) begin
        done_cyc = k;
        break;
      end
      rec_ready = 1'b1;
      if (rec_valid && stall_pat >= 0 && rec_data[4:1] == stall_pat[3:0] &&
          stalled < stall_len) begin
        rec_ready = 1'b0;
        stalled++;
        sp = stall_pat[3:0];
        checks++;
        if (rec_data !== {sp, ^sp}) begin
          errors++;
          $display("FAIL stall_data: got %b, want %b", rec_data, {sp, ^sp});
        end
      end
      if (rec_valid && stray_pat >= 0 && rec_data[4:1] == stray_pat[3:0] && !stray_done) begin
        rec_ready = 1'b0;
        start = 1'b1;
        sv_n = n; sv_cnt = rec_count; sv_sig = signature; sv_data = rec_data;
        stray_done = 1; stray_chk = 1;
      end
      if (rec_valid && abort_pat >= 0 && rec_data[4:1] == abort_pat[3:0]) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        done_cyc = -2;
        break;
      end
      if (rec_valid && rec_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL record_extra: got %b, want no record", rec_data);
        end else begin
          exp = exp_q.pop_front();
          if (rec_data !== exp) begin
            errors++;
            $display("FAIL record: got %b, want %b", rec_data, exp);
          end
        end
        xfers++;
      end
      step();
      start = 1'b0;
    end
    if (done_cyc == -1) begin
      errors++;
      $display("FAIL sweep_timeout: got no done, want done within 400 cycles");
    end
    if (done_cyc >= 0) begin
      step();
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL done_pulse: got done=%b busy=%b, want 0 0", done, busy);
      end
    end
  endtask

  task automatic check_end(input string name, input int dc, input int want_dc, input int x);
    checks++;
    if (dc !== want_dc) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d, want %0d", name, dc, want_dc);
    end
    checks++;
    if ({signature, rec_count} !== {16'h6996, 5'd16} || x !== 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_result: got sig=%h cnt=%0d xfers=%0d left=%0d, want 6996 16 16 0",
               name, signature, rec_count, x, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; rec_ready = 1'b1;
    start3 = 1'b0; abort3 = 1'b0; rec_ready3 = 1'b1;
    #2;
    checks++;
    if ({n, rec_valid, rec_data, busy, done, signature, rec_count} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got N=%h v=%b d=%h b=%b dn=%b sig=%h cnt=%0d, want all 0",
               n, rec_valid, rec_data, busy, done, signature, rec_count);
    end
    checks++;
    if ({n3, rec_valid3, rec_data3, busy3, done3, signature3, rec_count3} !== '0) begin
      errors++;
      $display("FAIL reset_dut3: got N=%h v=%b sig=%h, want all 0", n3, rec_valid3, signature3);
    end
    @(negedge CK);
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({busy, rec_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b v=%b done=%b, want 0 0 0",
               busy, rec_valid, done);
    end
  endtask

  task automatic test_sweep();
    int dc, x;
    run_sweep(-1, 0, -1, -1, dc, x);
    check_end("sweep", dc, 32, x);
    checks++;
    if ({n, signature} !== {4'hf, 16'h6996}) begin
      errors++;
      $display("FAIL idle_hold: got N=%h sig=%h, want f 6996", n, signature);
    end
  endtask

  task automatic test_backpressure();
    int dc, x;
    run_sweep(7, 5, -1, -1, dc, x);
    check_end("backpressure", dc, 37, x);
  endtask

  task automatic test_stray_start();
    int dc, x;
    run_sweep(-1, 0, -1, 3, dc, x);
    check_end("stray", dc, 33, x);
  endtask

  task automatic test_abort();
    int dc, x;
    bit saw_done;
    run_sweep(-1, 0, 5, -1, dc, x);
    checks++;
    if (dc !== -2 || {busy, rec_valid, done, rec_count} !== {3'b000, 5'd5} || x !== 5) begin
      errors++;
      $display("FAIL abort_state: got dc=%0d busy=%b v=%b done=%b cnt=%0d x=%0d, want -2 0 0 0 5 5",
               dc, busy, rec_valid, done, rec_count, x);
    end
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done || rec_count !== 5'd5) begin
      errors++;
      $display("FAIL abort_quiet: got done_seen=%b cnt=%0d, want 0 5", saw_done, rec_count);
    end
    run_sweep(-1, 0, -1, -1, dc, x);
    check_end("after_abort", dc, 32, x);
  endtask

  task automatic test_async_reset();
    int dc, x;
    bit found;
    found = 0;
    rec_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n == 4'd6 && busy && !rec_valid) begin
        found = 1;
        break;
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_reach_apply: got no APPLY of pattern 6, want one");
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({n, rec_valid, rec_data, busy, done, signature, rec_count} !== '0) begin
      errors++;
      $display("FAIL async_reset: got N=%h v=%b d=%h b=%b sig=%h cnt=%0d, want all 0",
               n, rec_valid, rec_data, busy, signature, rec_count);
    end
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    @(negedge CK);
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({busy, n, signature} !== {1'b0, 4'd0, 16'd0}) begin
      errors++;
      $display("FAIL start_in_reset: got busy=%b N=%h sig=%h, want 0 0 0000", busy, n, signature);
    end
    run_sweep(-1, 0, -1, -1, dc, x);
    check_end("after_reset", dc, 32, x);
  endtask

  task automatic test_latency();
    int dc, x;
    logic [4:0] exp;
    dc = -1; x = 0;
    exp3_q.delete();
    push_all(1'b1);
    rec_ready3 = 1'b1;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done3) begin
        dc = k;
        break;
      end
      if (rec_valid3 && rec_ready3) begin
        checks++;
        if (exp3_q.size() == 0) begin
          errors++;
          $display("FAIL latency_extra: got %b, want no record", rec_data3);
        end else begin
          exp = exp3_q.pop_front();
          if (rec_data3 !== exp) begin
            errors++;
            $display("FAIL latency_record: got %b, want %b", rec_data3, exp);
          end
        end
        x++;
      end
      step();
    end
    checks++;
    if (dc !== 64) begin
      errors++;
      $display("FAIL latency_done_cycle: got %0d, want 64", dc);
    end
    checks++;
    if ({signature3, rec_count3} !== {16'h6996, 5'd16} || x !== 16) begin
      errors++;
      $display("FAIL latency_result: got sig=%h cnt=%0d x=%0d, want 6996 16 16",
               signature3, rec_count3, x);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_stray_start();
    test_abort();
    test_async_reset();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exhaustive_sweep_capture.md
# exhaustive_sweep_capture

Synthesizable, parametrised successor to the exhaustive stimulus benches used for the trojan-detection benchmarks. It drives every input pattern from 0 to 2^N_IN−1 into a DUT, holds each pattern for HOLD cycles, and samples the DUT response. Each {pattern, response} record is streamed out over a valid/ready interface, and a running signature is folded over all responses. It sits between a benchmark DUT wrapper and the result logger/compare logic.

## Interface
- N_IN, 4, DUT input width (1..16); sweep length 2^N_IN
- N_OUT, 1, DUT output width (1..16)
- HOLD, 1, cycles each pattern is applied before sampling (1..255)
- SIG_W, 16, signature width (≥ N_OUT)
- CK  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin sweep; sampled only in IDLE
- abort  input  1  terminate sweep; return to IDLE
- N  output  N_IN  pattern driven to DUT
- dut_out  input  N_OUT  DUT response
- rec_valid  output  1  record available
- rec_ready  input  1  consumer accepts record
- rec_data  output  N_IN+N_OUT  {pattern, response}, pattern in MSBs
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse on sweep completion
- signature  output  SIG_W  response signature
- rec_count  output  N_IN+1  records accepted this sweep

## Operation
- States: IDLE, APPLY, EMIT, DONE.
- IDLE:
  - busy=0, N holds its last value.
  - start=1 → APPLY. On the same edge: N=0, signature=0, rec_count=0, hold counter=0.
- APPLY:
  - busy=1, N stable.
  - The hold counter increments each cycle.
  - On the edge ending the HOLD-th APPLY cycle: capture dut_out into the response register, fold it into the signature, go to EMIT.
- Signature fold: signature ← rotl1(signature) XOR zero-extend(response).
- EMIT:
  - rec_valid=1; rec_data={N, response}, stable until accepted.
  - Transfer occurs on an edge with rec_valid & rec_ready; rec_count increments on that edge.
  - After the transfer, if N = all ones → DONE. Otherwise N←N+1, hold counter=0, → APPLY.
  - rec_ready low holds EMIT indefinitely, with no data change and no signature change.
- DONE:
  - Lasts one cycle: done=1, busy=0.
  - Then → IDLE.
  - signature and rec_count hold until the next start.
- abort=1 in APPLY or EMIT:
  - → IDLE on the next edge. rec_valid drops, done is not asserted, signature and rec_count freeze.
  - abort has priority over a simultaneous transfer: that record is not counted.
- start while busy is ignored. start and abort together in IDLE → stay IDLE.
- The pattern never wraps: the increment from all ones never occurs.

## Timing
- Reset values (asynchronous, active-low): state=IDLE, N=0, rec_valid=0, rec_data=0, busy=0, done=0, signature=0, rec_count=0, hold counter=0.
- Reset asserted mid-sweep aborts immediately. After release, the block waits for a new start.
- busy rises on the edge that samples start; N=0 is driven from that edge.
- Per-pattern cost: HOLD cycles in APPLY plus ≥1 cycle in EMIT.
- Sweep length with rec_ready=1 throughout: 2^N_IN × (HOLD+1) cycles from the start edge to entering DONE.
- done is high exactly one cycle, on the cycle after the last transfer.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Exhaustive sweep: N_IN=4, N_OUT=1, HOLD=1, dut_out=^N, rec_ready=1, start pulsed.
  - 16 records with patterns 0..15 and responses 0110100110010110.
  - signature=0x6996, rec_count=16.
  - done pulses 32 cycles after the start edge.
- Backpressure: same setup, rec_ready low for 5 cycles during pattern 7.
  - rec_data={0111,1} stays stable for the whole stall.
  - No duplicate or dropped records.
  - signature still 0x6996; done is delayed by exactly 5 cycles.
- HOLD=3 with a DUT that has 2-cycle latency (registered ^N):
  - Every response equals the parity of its own pattern.
  - Total 64 cycles.
- Abort: abort asserted during EMIT of pattern 5 with rec_ready=1 on the same edge.
  - Next cycle: IDLE, rec_valid=0, rec_count=5, no done pulse.
  - A new start restarts from N=0 with signature=0.
- Async reset: reset driven low mid-APPLY, between clock edges.
  - All outputs go to their reset values immediately.
  - start is ignored while reset is low.
  - After release, a full sweep reproduces 0x6996.
- Stray start: start pulsed while busy → no effect on N, rec_count or signature.
